multi_digit_timer: RTL and testbench
====================================

MULTI_DIGIT_TIMER -- requirements
Module: multi_digit_timer

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of cascaded countdown digits (1..8).
REQ-002 Parameter DIGIT_W, default 4, bits per digit.
REQ-003 Parameter RADIX, default 10, modulus of every digit (2..2**DIGIT_W).
REQ-004 Port clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1, synchronous reset, active-high.
REQ-006 Port load, input, 1, load count and reload register from load_value.
REQ-007 Port load_value, input, NUM_DIGITS*DIGIT_W, packed digits; digit 0 in the LSBs.
REQ-008 Port tick, input, 1, one-cycle decrement request.
REQ-009 Port pause, input, 1, level; while high, tick is ignored.
REQ-010 Port auto_reload, input, 1, mode; 1 = restart from the reload register on a tick at zero.
REQ-011 Port count, output, NUM_DIGITS*DIGIT_W, current packed digit value.
REQ-012 Port zero, output, 1, high while every digit equals 0.
REQ-013 Port expired, output, 1, one-cycle pulse when the count reaches zero.
REQ-014 Port reloaded, output, 1, one-cycle pulse when an auto-reload occurs.

Function
REQ-015 Priority each cycle: rst > load > tick; pause only masks tick.
REQ-016 Load: count and reload register take load_value in the next cycle; any digit >= RADIX is clamped to RADIX-1; expired and reloaded = 0 in that cycle.
REQ-017 Tick with pause=0 and count nonzero: count decrements by one as a radix-RADIX number; digit i decrements only when digits 0..i-1 are all 0, and wraps from 0 to RADIX-1.
REQ-018 Tick that moves count from 1 to 0: expired = 1 in the following cycle only; zero = 1 from that cycle on.
REQ-019 Tick at zero with auto_reload=1: count takes the reload register; reloaded = 1 for one cycle; expired does not re-pulse.
REQ-020 Tick at zero with auto_reload=0: count holds at 0; no pulses.
REQ-021 Load value of all zeros: zero = 1 next cycle; expired is not pulsed.
REQ-022 Latency: count, zero, expired and reloaded are registered; each updates one cycle after the causing input.
REQ-023 Load and tick in the same cycle: load wins; the tick is dropped.
REQ-024 Reload of an all-zero reload register leaves count at 0 and still pulses reloaded.
REQ-025 Decrement and the borrow chain complete in one cycle for any NUM_DIGITS.

Reset
REQ-026 rst = 1: every digit = RADIX-1; reload register = every digit RADIX-1; zero = 0; expired = 0; reloaded = 0.
REQ-027 rst asserted mid-count overrides load and tick in that cycle; no pulse is emitted.

Structure
REQ-028 Package timer_pkg holds the default NUM_DIGITS, DIGIT_W and RADIX constants and a per-digit clamp function.
REQ-029 Sub-module timer_digit: one digit register with borrow_in, borrow_out, load and clamp; it is instantiated NUM_DIGITS times by a generate loop.
REQ-030 Zero detect is a reduction over the digit-zero flags driven out of timer_digit.

Verification
REQ-031 Reset then no stimulus -> count = 16'h9999 and zero = 0 (defaults).
REQ-032 Load 16'h0100 followed by one tick -> count = 16'h0099; a further 99 ticks -> count = 0 and expired pulses exactly once.
REQ-033 Load 16'h0002 with auto_reload=1 and 3 ticks -> count sequence 1, 0, 2; expired pulses after tick 2 and reloaded pulses after tick 3.
REQ-034 Load 16'h00F5 -> count = 16'h0095 (clamp); tick held high with pause = 1 for 10 cycles -> count unchanged.
REQ-035 Load and tick asserted in the same cycle with load_value 16'h0005 -> count = 16'h0005; rst asserted at count 16'h0003 -> count = 16'h9999 and no pulse.
REQ-036 Parameter sweep NUM_DIGITS=2, RADIX=6: load 8'h10 and apply one tick -> count = 8'h05.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared defaults and the digit clamp helper for the cascaded countdown timer.
package timer_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_RADIX      = 10;

    // Digits outside the radix saturate to the largest legal digit.
    function automatic logic [31:0] clamp_digit(
        input logic [31:0] d,
        input int          radix
    );
        logic [31:0] r;
        r = 32'(radix);
        return (d >= r) ? (r - 32'd1) : d;
    endfunction

endpackage

// File: rtl/timer_digit.sv
// One countdown digit: count and reload registers, clamp on load, borrow chain.
module timer_digit
    import timer_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int RADIX   = DEF_RADIX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               reload,
    input  logic               dec,
    input  logic               borrow_in,
    output logic               borrow_out,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_zero,
    output logic               next_zero
);

    localparam logic [DIGIT_W-1:0] MAXD = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] count_q, count_d;
    logic [DIGIT_W-1:0] rel_q, rel_d;
    logic [DIGIT_W-1:0] clamped;

    assign clamped = DIGIT_W'(clamp_digit(32'(load_digit), RADIX));

    always_comb begin
        count_d = count_q;
        rel_d   = rel_q;
        if (load) begin
            count_d = clamped;
            rel_d   = clamped;
        end else if (reload) begin
            count_d = rel_q;
        end else if (dec && borrow_in) begin
            count_d = (count_q == '0) ? MAXD : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MAXD;
            rel_q   <= MAXD;
        end else begin
            count_q <= count_d;
            rel_q   <= rel_d;
        end
    end

    assign digit      = count_q;
    assign is_zero    = (count_q == '0);
    assign next_zero  = (count_d == '0);
    assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/multi_digit_timer.sv
// Cascaded radix-N countdown timer with load, pause and optional auto-reload.
module multi_digit_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int RADIX      = DEF_RADIX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
    input  logic                          tick,
    input  logic                          pause,
    input  logic                          auto_reload,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic                          zero,
    output logic                          expired,
    output logic                          reloaded
);

    logic [NUM_DIGITS-1:0] dig_zero;
    logic [NUM_DIGITS-1:0] nxt_zero;
    logic                  at_zero;
    logic                  tick_en;
    logic                  dec_en;
    logic                  reload_en;
    logic                  expired_q, expired_d;
    logic                  reloaded_q, reloaded_d;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic bin;
        logic bout;
        if (i == 0) begin : g_first
            assign bin = 1'b1;
        end else begin : g_rest
            assign bin = g_digit[i-1].bout;
        end
        timer_digit #(
            .DIGIT_W (DIGIT_W),
            .RADIX   (RADIX)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_value[i*DIGIT_W +: DIGIT_W]),
            .reload     (reload_en),
            .dec        (dec_en),
            .borrow_in  (bin),
            .borrow_out (bout),
            .digit      (count[i*DIGIT_W +: DIGIT_W]),
            .is_zero    (dig_zero[i]),
            .next_zero  (nxt_zero[i])
        );
    end

    // A borrow out of the top digit means the whole count is already zero.
    assign at_zero   = g_digit[NUM_DIGITS-1].bout;
    assign tick_en   = tick & ~pause & ~load;
    assign dec_en    = tick_en & ~at_zero;
    assign reload_en = tick_en & at_zero & auto_reload;

    always_comb begin
        expired_d  = dec_en & (&nxt_zero);
        reloaded_d = reload_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expired_q  <= 1'b0;
            reloaded_q <= 1'b0;
        end else begin
            expired_q  <= expired_d;
            reloaded_q <= reloaded_d;
        end
    end

    assign zero     = &dig_zero;
    assign expired  = expired_q;
    assign reloaded = reloaded_q;

endmodule

// File: tb/tb_multi_digit_timer.sv
// Directed scoreboard bench for multi_digit_timer (default and 2-digit radix-6).
module tb_multi_digit_timer;

    localparam int N1 = 4;
    localparam int W1 = 4;
    localparam int R1 = 10;

    typedef struct packed {
        logic [15:0] count;
        logic        zero;
        logic        expired;
        logic        reloaded;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] load_value;
    logic        tick;
    logic        pause;
    logic        auto_reload;
    logic [15:0] count;
    logic        zero;
    logic        expired;
    logic        reloaded;

    logic        load2;
    logic [7:0]  load_value2;
    logic        tick2;
    logic        pause2;
    logic        auto2;
    logic [7:0]  count2;
    logic        zero2;
    logic        expired2;
    logic        reloaded2;

    int total = 0;
    int passed = 0;
    int exp_seen = 0;

    int m_val;
    int m_rel;
    bit m_exp;
    bit m_rl;

    exp_t sb[$];

    always #5 clk = ~clk;

    multi_digit_timer u_dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_value  (load_value),
        .tick        (tick),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .expired     (expired),
        .reloaded    (reloaded)
    );

    multi_digit_timer #(
        .NUM_DIGITS (2),
        .DIGIT_W    (4),
        .RADIX      (6)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .load        (load2),
        .load_value  (load_value2),
        .tick        (tick2),
        .pause       (pause2),
        .auto_reload (auto2),
        .count       (count2),
        .zero        (zero2),
        .expired     (expired2),
        .reloaded    (reloaded2)
    );

    function automatic logic [31:0] to_packed(int v, int r, int n, int w);
        logic [31:0] res;
        int          x;
        res = '0;
        x   = v;
        for (int i = 0; i < n; i++) begin
            res = res | (32'(x % r) << (i * w));
            x   = x / r;
        end
        return res;
    endfunction

    function automatic int from_load(logic [31:0] lv, int r, int n, int w);
        int v;
        int d;
        v = 0;
        for (int i = n - 1; i >= 0; i--) begin
            d = int'((lv >> (i * w)) & ((32'd1 << w) - 32'd1));
            if (d >= r) d = r - 1;
            v = v * r + d;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] lv, input bit tk,
                        input bit ps, input bit ar, input bit rs);
        exp_t e;
        exp_t g;
        rst         = rs;
        load        = ld;
        load_value  = lv;
        tick        = tk;
        pause       = ps;
        auto_reload = ar;
        if (rs) begin
            m_val = 9999;
            m_rel = 9999;
            m_exp = 0;
            m_rl  = 0;
        end else if (ld) begin
            m_val = from_load(32'(lv), R1, N1, W1);
            m_rel = m_val;
            m_exp = 0;
            m_rl  = 0;
        end else if (tk && !ps) begin
            if (m_val != 0) begin
                m_val = m_val - 1;
                m_exp = (m_val == 0);
                m_rl  = 0;
            end else if (ar) begin
                m_val = m_rel;
                m_exp = 0;
                m_rl  = 1;
            end else begin
                m_exp = 0;
                m_rl  = 0;
            end
        end else begin
            m_exp = 0;
            m_rl  = 0;
        end
        e.count    = 16'(to_packed(m_val, R1, N1, W1));
        e.zero     = (m_val == 0);
        e.expired  = m_exp;
        e.reloaded = m_rl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        if (expired === 1'b1) exp_seen++;
        chk("count", 32'(count), 32'(g.count));
        chk("zero", 32'(zero), 32'(g.zero));
        chk("expired", 32'(expired), 32'(g.expired));
        chk("reloaded", 32'(reloaded), 32'(g.reloaded));
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        load_value = '0;
        tick = 1'b0;
        pause = 1'b0;
        auto_reload = 1'b0;
        load2 = 1'b0;
        load_value2 = '0;
        tick2 = 1'b0;
        pause2 = 1'b0;
        auto2 = 1'b0;

        step(0, 16'h0000, 0, 0, 0, 1);
        step(0, 16'h0000, 0, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 0, 0);

        step(1, 16'h0100, 0, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0, 0);
        chk("count_0099", 32'(count), 32'h0099);
        exp_seen = 0;
        for (int i = 0; i < 99; i++) step(0, 16'h0000, 1, 0, 0, 0);
        chk("expired_once", 32'(exp_seen), 32'd1);
        step(0, 16'h0000, 1, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 0, 0);

        step(1, 16'h0002, 0, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 1, 0);

        step(1, 16'h00F5, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 16'h0000, 1, 1, 0, 0);
        step(1, 16'hFAB7, 0, 0, 0, 0);

        step(1, 16'h0005, 1, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0, 0);
        step(1, 16'h0001, 1, 0, 0, 1);
        step(0, 16'h0000, 0, 0, 0, 0);

        step(1, 16'h0000, 0, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 1, 0);
        step(0, 16'h0000, 1, 0, 0, 0);

        step(1, 16'h1000, 0, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0, 0);

        load2 = 1'b1;
        load_value2 = 8'h10;
        @(posedge clk);
        #1;
        chk("d2_load", 32'(count2), 32'h10);
        load2 = 1'b0;
        tick2 = 1'b1;
        @(posedge clk);
        #1;
        chk("d2_tick", 32'(count2), 32'h05);
        chk("d2_zero", 32'(zero2), 32'd0);
        tick2 = 1'b0;
        load2 = 1'b1;
        load_value2 = 8'h99;
        @(posedge clk);
        #1;
        chk("d2_clamp", 32'(count2), 32'h55);
        load2 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
